traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter TOL, default 1: allowed +/- deviation, in clocks, of a measured green or yellow phase length.
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 LEWG, LEWY, LEWR  input  1 each  east-west green/yellow/red lamp drives from the light controller.
REQ-005 LSNG, LSNY, LSNR  input  1 each  south-north green/yellow/red lamp drives.
REQ-006 r  input  6  expected green length in clocks; y  input  6  expected yellow length in clocks.
REQ-007 clr  input  1  clears fault_sticky.
REQ-008 phase  output  3  decoded phase: 001 EWG, 010 EWY, 011 SNG, 100 SNY, 111 ALLR, 110 ILL.
REQ-009 phase_timer  output  8  clocks spent in the current phase; last_len  output  8  length of the previous phase.
REQ-010 lamp_err, seq_err, dur_err  output  1 each  single-cycle fault pulses; fault_sticky  output  1  OR of all faults since the last clear.
REQ-011 cycles_done  output  16  count of completed full signal cycles.

Function
REQ-012 The block SHALL register all six lamp inputs each clock, then decode phase from the registered copy, giving a total latency of 2 clocks from lamp input to phase output.
REQ-013 Decode: EWG = EW G only with SN R only; EWY = EW Y with SN R; SNG = SN G with EW R; SNY = SN Y with EW R; ALLR = both R only; any other combination, including multiple lamps in one direction or no lamps, = ILL.
REQ-014 Decoding ILL SHALL pulse lamp_err for 1 clock in the cycle phase loads 110; a held ILL pulses only on entry.
REQ-015 Legal changes: ALLR->EWG, EWG->EWY, EWY->SNG, SNG->SNY, SNY->EWG, and any phase->ALLR; any other change SHALL pulse seq_err in the load cycle.
REQ-016 A change into or out of ILL SHALL NOT pulse seq_err; lamp_err covers that case.
REQ-017 Holding the same phase is always legal.
REQ-018 On a phase change: last_len <= phase_timer (old value); phase_timer <= 1.
REQ-019 While the phase is unchanged, phase_timer SHALL increment and saturate at 255.
REQ-020 Duration check, evaluated on change out of EWG/SNG: pulse dur_err if last_len is outside [r-TOL, r+TOL].
REQ-021 Duration check, evaluated on change out of EWY/SNY: pulse dur_err if last_len is outside [y-TOL, y+TOL].
REQ-022 The duration check SHALL NOT be evaluated when leaving ALLR or ILL, nor when the relevant r or y is 0; the lower bound floors at 0.
REQ-023 Duration and range arithmetic SHALL be at least 9 bits wide so the comparison cannot wrap.
REQ-024 cycles_done SHALL increment on every SNY->EWG change and wrap from 65535 to 0.
REQ-025 fault_sticky SHALL set on any fault pulse and clear on clr; if clr and a fault occur in the same cycle, the fault wins and fault_sticky stays 1.
REQ-026 Multiple faults in one cycle SHALL all pulse simultaneously.

Reset
REQ-027 When rst=1 at a clock edge, the registered lamp copy and phase SHALL become ALLR, and phase_timer, last_len, cycles_done, all fault pulses and fault_sticky SHALL become 0.
REQ-028 Reset asserted mid-phase SHALL abort measurement without any fault pulse; the first ALLR->EWG change after reset is legal.

Configuration
REQ-029 With MON_DUR_CHECK_EN defined, REQ-020 to REQ-023 are implemented.
REQ-030 Without MON_DUR_CHECK_EN, dur_err SHALL be constant 0, r and y SHALL be unused, and last_len and phase_timer SHALL be unchanged.

Verification
REQ-031 Legal cycle: r=5, y=2, TOL=1; ALLR, then EWG 5, EWY 2, SNG 5, SNY 2 clocks, then EWG -> no faults, cycles_done=1, last_len=2.
REQ-032 Long green: r=5, EWG held 8 clocks then EWY -> dur_err 1-clock pulse on EWY entry, last_len=8, fault_sticky=1 (with MON_DUR_CHECK_EN); no pulse without it.
REQ-033 Illegal lamps: LEWG=LSNG=1 for 3 clocks -> phase=110, exactly one lamp_err pulse, no seq_err.
REQ-034 Skipped yellow: EWG directly to SNG -> seq_err pulse; clr asserted the same cycle -> fault_sticky remains 1, then clears on the next clr.
REQ-035 Saturation/reset: EWG held 300 clocks -> phase_timer=255; rst pulsed mid-phase -> all outputs 0, phase=111, no fault pulse.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//
// Purpose:
//   Passive monitor for a two-direction traffic light controller. It registers
//   the six lamp drives, decodes the registered copy into a phase, checks that
//   lamp combinations are legal, checks the order of phase changes, optionally
//   checks green/yellow phase lengths against expected values, and counts
//   completed signal cycles.
//
// Configuration:
//   MON_DUR_CHECK_EN - when defined, the green/yellow duration check drives
//                      o_dur_err. When undefined, o_dur_err is held at 0 and
//                      i_r / i_y are ignored.
//
// Parameters:
//   TOL              - allowed +/- deviation, in clocks, of a green/yellow length
//
// Ports:
//   i_clk            - system clock, rising edge
//   i_rst            - synchronous active-high reset
//   i_lewg/y/r       - east-west green/yellow/red lamp drives
//   i_lsng/y/r       - south-north green/yellow/red lamp drives
//   i_r              - expected green length in clocks
//   i_y              - expected yellow length in clocks
//   i_clr            - clears o_fault_sticky
//   o_phase          - decoded phase (001 EWG, 010 EWY, 011 SNG, 100 SNY,
//                      111 ALLR, 110 ILL)
//   o_phase_timer    - clocks spent in the current phase, saturates at 255
//   o_last_len       - length of the previous phase
//   o_lamp_err       - 1-clock pulse on entry into ILL
//   o_seq_err        - 1-clock pulse on an out-of-order phase change
//   o_dur_err        - 1-clock pulse when a green/yellow length is out of range
//   o_fault_sticky   - OR of all fault pulses since the last clear
//   o_cycles_done    - number of SNY->EWG changes, wraps at 16 bits
//
// State table (the monitored phase is the FSM state):
//   state   | meaning
//   PH_EWG  | east-west green, south-north red
//   PH_EWY  | east-west yellow, south-north red
//   PH_SNG  | south-north green, east-west red
//   PH_SNY  | south-north yellow, east-west red
//   PH_ALLR | both directions red (reset state)
//   PH_ILL  | any other lamp combination
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
  parameter int TOL = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lewg,
  input  logic        i_lewy,
  input  logic        i_lewr,
  input  logic        i_lsng,
  input  logic        i_lsny,
  input  logic        i_lsnr,
  input  logic [5:0]  i_r,
  input  logic [5:0]  i_y,
  input  logic        i_clr,
  output logic [2:0]  o_phase,
  output logic [7:0]  o_phase_timer,
  output logic [7:0]  o_last_len,
  output logic        o_lamp_err,
  output logic        o_seq_err,
  output logic        o_dur_err,
  output logic        o_fault_sticky,
  output logic [15:0] o_cycles_done
);

  typedef enum logic [2:0] {
    PH_EWG  = 3'b001,
    PH_EWY  = 3'b010,
    PH_SNG  = 3'b011,
    PH_SNY  = 3'b100,
    PH_ILL  = 3'b110,
    PH_ALLR = 3'b111
  } phase_t;

  // Lamp vector order: {EW G, EW Y, EW R, SN G, SN Y, SN R}
  localparam logic [5:0] LAMP_EWG  = 6'b100_001;
  localparam logic [5:0] LAMP_EWY  = 6'b010_001;
  localparam logic [5:0] LAMP_SNG  = 6'b001_100;
  localparam logic [5:0] LAMP_SNY  = 6'b001_010;
  localparam logic [5:0] LAMP_ALLR = 6'b001_001;

  // 10-bit range arithmetic: 6-bit reference plus tolerance can never wrap.
  localparam logic [9:0] TOL_W = 10'(TOL);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [5:0]  r_lamp;
  phase_t      r_phase;
  logic [7:0]  r_timer;
  logic [7:0]  r_last;
  logic [15:0] r_cycles;
  logic        r_lamp_err;
  logic        r_seq_err;
  logic        r_dur_err;
  logic        r_sticky;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic [5:0]  w_lamp_in;
  phase_t      w_dec;
  logic        w_change;
  logic        w_legal;
  logic        w_seq;
  logic        w_ill;
  logic        w_dur;
  logic [7:0]  w_nxt_timer;
  logic [7:0]  w_nxt_last;
  logic [15:0] w_nxt_cycles;
  logic        w_nxt_sticky;

  assign w_lamp_in = {i_lewg, i_lewy, i_lewr, i_lsng, i_lsny, i_lsnr};

  // Phase decode from the registered lamp copy.
  always_comb begin
    w_dec = PH_ILL;
    case (r_lamp)
      LAMP_EWG:  w_dec = PH_EWG;
      LAMP_EWY:  w_dec = PH_EWY;
      LAMP_SNG:  w_dec = PH_SNG;
      LAMP_SNY:  w_dec = PH_SNY;
      LAMP_ALLR: w_dec = PH_ALLR;
      default:   w_dec = PH_ILL;
    endcase
  end

  assign w_change = (w_dec != r_phase);

  // Order check. Any phase may drop to all-red; otherwise only the single
  // successor in the EWG->EWY->SNG->SNY->EWG ring is allowed.
  always_comb begin
    w_legal = 1'b0;
    if (w_dec == PH_ALLR) begin
      w_legal = 1'b1;
    end else begin
      case (r_phase)
        PH_ALLR: w_legal = (w_dec == PH_EWG);
        PH_EWG:  w_legal = (w_dec == PH_EWY);
        PH_EWY:  w_legal = (w_dec == PH_SNG);
        PH_SNG:  w_legal = (w_dec == PH_SNY);
        PH_SNY:  w_legal = (w_dec == PH_EWG);
        default: w_legal = 1'b0;
      endcase
    end
  end

  // Transitions touching ILL are reported by lamp_err alone.
  assign w_seq = w_change && !w_legal && (r_phase != PH_ILL) && (w_dec != PH_ILL);
  assign w_ill = w_change && (w_dec == PH_ILL);

`ifdef MON_DUR_CHECK_EN
  logic [9:0] w_ref;
  logic [9:0] w_lo;
  logic [9:0] w_hi;
  logic [9:0] w_len;
  logic       w_chk;

  // The length being judged is the old timer value, i.e. the value that
  // becomes last_len on this change.
  always_comb begin
    w_ref = 10'd0;
    w_chk = 1'b0;
    case (r_phase)
      PH_EWG, PH_SNG: begin
        w_ref = {4'd0, i_r};
        w_chk = 1'b1;
      end
      PH_EWY, PH_SNY: begin
        w_ref = {4'd0, i_y};
        w_chk = 1'b1;
      end
      default: begin
        w_ref = 10'd0;
        w_chk = 1'b0;
      end
    endcase
    w_hi  = w_ref + TOL_W;
    // Lower bound floors at zero instead of wrapping.
    w_lo  = (w_ref > TOL_W) ? (w_ref - TOL_W) : 10'd0;
    w_len = {2'd0, r_timer};
    w_dur = w_change && w_chk && (w_ref != 10'd0) && ((w_len < w_lo) || (w_len > w_hi));
  end
`else
  logic w_unused_ry;
  assign w_unused_ry = ^{i_r, i_y, TOL_W};
  assign w_dur       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_nxt_timer  = r_timer;
    w_nxt_last   = r_last;
    w_nxt_cycles = r_cycles;
    w_nxt_sticky = r_sticky;

    if (w_change) begin
      w_nxt_last  = r_timer;
      w_nxt_timer = 8'd1;
      if ((r_phase == PH_SNY) && (w_dec == PH_EWG)) begin
        w_nxt_cycles = r_cycles + 16'd1;
      end
    end else if (r_timer != 8'hFF) begin
      w_nxt_timer = r_timer + 8'd1;
    end

    // A fault in the same cycle as clr keeps the sticky flag set.
    if (w_ill || w_seq || w_dur) begin
      w_nxt_sticky = 1'b1;
    end else if (i_clr) begin
      w_nxt_sticky = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lamp     <= LAMP_ALLR;
      r_phase    <= PH_ALLR;
      r_timer    <= 8'd0;
      r_last     <= 8'd0;
      r_cycles   <= 16'd0;
      r_lamp_err <= 1'b0;
      r_seq_err  <= 1'b0;
      r_dur_err  <= 1'b0;
      r_sticky   <= 1'b0;
    end else begin
      r_lamp     <= w_lamp_in;
      r_phase    <= w_dec;
      r_timer    <= w_nxt_timer;
      r_last     <= w_nxt_last;
      r_cycles   <= w_nxt_cycles;
      r_lamp_err <= w_ill;
      r_seq_err  <= w_seq;
      r_dur_err  <= w_dur;
      r_sticky   <= w_nxt_sticky;
    end
  end

  assign o_phase        = r_phase;
  assign o_phase_timer  = r_timer;
  assign o_last_len     = r_last;
  assign o_cycles_done  = r_cycles;
  assign o_lamp_err     = r_lamp_err;
  assign o_seq_err      = r_seq_err;
  assign o_dur_err      = r_dur_err;
  assign o_fault_sticky = r_sticky;

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

  localparam int TOL = 1;

`ifdef MON_DUR_CHECK_EN
  localparam bit DUR_ON = 1'b1;
`else
  localparam bit DUR_ON = 1'b0;
`endif

  localparam logic [2:0] P_EWG  = 3'b001;
  localparam logic [2:0] P_EWY  = 3'b010;
  localparam logic [2:0] P_SNG  = 3'b011;
  localparam logic [2:0] P_SNY  = 3'b100;
  localparam logic [2:0] P_ILL  = 3'b110;
  localparam logic [2:0] P_ALLR = 3'b111;

  // {EW G, EW Y, EW R, SN G, SN Y, SN R}
  localparam logic [5:0] L_EWG  = 6'b100_001;
  localparam logic [5:0] L_EWY  = 6'b010_001;
  localparam logic [5:0] L_SNG  = 6'b001_100;
  localparam logic [5:0] L_SNY  = 6'b001_010;
  localparam logic [5:0] L_ALLR = 6'b001_001;
  localparam logic [5:0] L_BOTHG = 6'b100_100;

  logic        clk = 1'b0;
  logic        rst, lewg, lewy, lewr, lsng, lsny, lsnr, clr;
  logic [5:0]  r, y;
  logic [2:0]  phase;
  logic [7:0]  phase_timer, last_len;
  logic        lamp_err, seq_err, dur_err, fault_sticky;
  logic [15:0] cycles_done;

  always #5 clk = ~clk;

  traffic_light_monitor #(.TOL(TOL)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_lewg(lewg), .i_lewy(lewy), .i_lewr(lewr),
    .i_lsng(lsng), .i_lsny(lsny), .i_lsnr(lsnr),
    .i_r(r), .i_y(y), .i_clr(clr),
    .o_phase(phase), .o_phase_timer(phase_timer), .o_last_len(last_len),
    .o_lamp_err(lamp_err), .o_seq_err(seq_err), .o_dur_err(dur_err),
    .o_fault_sticky(fault_sticky), .o_cycles_done(cycles_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (phase-level view of the light sequence)
  logic [5:0] m_lamp;
  logic [2:0] m_ph;
  int         m_timer, m_last, m_cycles;
  bit         e_lamp, e_seq, e_dur, m_sticky;

  function automatic logic [2:0] decode(input logic [5:0] l);
    if (l == L_EWG)  return P_EWG;
    if (l == L_EWY)  return P_EWY;
    if (l == L_SNG)  return P_SNG;
    if (l == L_SNY)  return P_SNY;
    if (l == L_ALLR) return P_ALLR;
    return P_ILL;
  endfunction

  function automatic logic [5:0] lamps_of(input logic [2:0] p);
    case (p)
      P_EWG:   return L_EWG;
      P_EWY:   return L_EWY;
      P_SNG:   return L_SNG;
      P_SNY:   return L_SNY;
      default: return L_ALLR;
    endcase
  endfunction

  function automatic logic [2:0] successor(input logic [2:0] p);
    case (p)
      P_EWG:   return P_EWY;
      P_EWY:   return P_SNG;
      P_SNG:   return P_SNY;
      P_SNY:   return P_EWG;
      default: return P_EWG;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [5:0] lamps, input bit c, input bit rs);
    logic [2:0] np;
    int ref_len;
    if (rs) begin
      m_lamp = L_ALLR; m_ph = P_ALLR;
      m_timer = 0; m_last = 0; m_cycles = 0;
      e_lamp = 0; e_seq = 0; e_dur = 0; m_sticky = 0;
    end else begin
      np = decode(m_lamp);
      m_lamp = lamps;
      e_lamp = 0; e_seq = 0; e_dur = 0;
      if (np != m_ph) begin
        e_lamp = (np == P_ILL);
        e_seq  = (m_ph != P_ILL) && (np != P_ILL) && (np != P_ALLR) && (np != successor(m_ph));
        if (m_ph == P_ALLR && np == P_EWG) e_seq = 0;
        if (m_ph == P_ALLR && np != P_EWG && np != P_ALLR && np != P_ILL) e_seq = 1;
        ref_len = 0;
        if (m_ph == P_EWG || m_ph == P_SNG) ref_len = int'(r);
        if (m_ph == P_EWY || m_ph == P_SNY) ref_len = int'(y);
        if (DUR_ON && ref_len != 0)
          e_dur = (m_timer < ref_len - TOL) || (m_timer > ref_len + TOL);
        if (m_ph == P_SNY && np == P_EWG) m_cycles = (m_cycles + 1) % 65536;
        m_last = m_timer;
        m_timer = 1;
        m_ph = np;
      end else begin
        m_timer = (m_timer < 255) ? m_timer + 1 : 255;
      end
      if (e_lamp || e_seq || e_dur) m_sticky = 1;
      else if (c) m_sticky = 0;
    end
  endtask

  task automatic step(input logic [5:0] lamps, input bit c, input bit rs);
    {lewg, lewy, lewr, lsng, lsny, lsnr} = lamps;
    clr = c;
    rst = rs;
    @(posedge clk);
    model(lamps, c, rs);
    #1;
    check("phase",        16'(phase),        16'(m_ph));
    check("phase_timer",  16'(phase_timer),  16'(m_timer));
    check("last_len",     16'(last_len),     16'(m_last));
    check("cycles_done",  cycles_done,       16'(m_cycles));
    check("lamp_err",     16'(lamp_err),     16'(e_lamp));
    check("seq_err",      16'(seq_err),      16'(e_seq));
    check("dur_err",      16'(dur_err),      16'(e_dur));
    check("fault_sticky", 16'(fault_sticky), 16'(m_sticky));
  endtask

  task automatic hold(input logic [5:0] lamps, input int n);
    for (int i = 0; i < n; i++) step(lamps, 1'b0, 1'b0);
  endtask

  initial begin
    int lamp_cnt, seq_cnt, len, kind;
    logic [2:0] drv;
    logic [5:0] v;

    r = 6'd5; y = 6'd2;
    {lewg, lewy, lewr, lsng, lsny, lsnr} = L_ALLR;
    clr = 0; rst = 1;
    m_lamp = L_ALLR; m_ph = P_ALLR; m_timer = 0; m_last = 0; m_cycles = 0;
    e_lamp = 0; e_seq = 0; e_dur = 0; m_sticky = 0;

    // Reset state
    step(L_ALLR, 0, 1);
    step(L_ALLR, 0, 1);
    check("rst_phase", 16'(phase), 16'(P_ALLR));
    check("rst_timer", 16'(phase_timer), 16'd0);

    // Legal full cycle
    hold(L_ALLR, 3);
    hold(L_EWG, 5); hold(L_EWY, 2); hold(L_SNG, 5); hold(L_SNY, 2);
    hold(L_EWG, 3);
    check("cycle_cycles_done", cycles_done, 16'd1);
    check("cycle_last_len", 16'(last_len), 16'd2);
    check("cycle_sticky", 16'(fault_sticky), 16'd0);

    // Long green
    step(L_ALLR, 0, 1);
    hold(L_ALLR, 2); hold(L_EWG, 8); hold(L_EWY, 2);
    check("long_dur_err", 16'(dur_err), 16'(DUR_ON));
    check("long_last_len", 16'(last_len), 16'd8);
    check("long_sticky", 16'(fault_sticky), 16'(DUR_ON));
    hold(L_EWY, 1);
    check("long_dur_single", 16'(dur_err), 16'd0);

    // Illegal lamps: both greens for 3 clocks
    step(L_ALLR, 0, 1);
    hold(L_ALLR, 2); hold(L_EWG, 3);
    lamp_cnt = 0; seq_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(L_BOTHG, 0, 0);
      lamp_cnt += int'(lamp_err); seq_cnt += int'(seq_err);
    end
    check("ill_phase", 16'(phase), 16'(P_ILL));
    for (int i = 0; i < 3; i++) begin
      step(L_ALLR, 0, 0);
      lamp_cnt += int'(lamp_err); seq_cnt += int'(seq_err);
    end
    check("ill_lamp_pulses", 16'(lamp_cnt), 16'd1);
    check("ill_seq_pulses", 16'(seq_cnt), 16'd0);

    // Skipped yellow with clr in the fault cycle
    step(L_ALLR, 0, 1);
    hold(L_ALLR, 2); hold(L_EWG, 5);
    step(L_SNG, 0, 0);
    step(L_SNG, 1, 0);
    check("skip_seq_err", 16'(seq_err), 16'd1);
    check("skip_sticky_wins", 16'(fault_sticky), 16'd1);
    step(L_SNG, 1, 0);
    check("skip_sticky_clr", 16'(fault_sticky), 16'd0);

    // Saturation then mid-phase reset
    step(L_ALLR, 0, 1);
    hold(L_ALLR, 2); hold(L_EWG, 300);
    check("sat_timer", 16'(phase_timer), 16'd255);
    step(L_EWG, 0, 1);
    check("rst_mid_phase", 16'(phase), 16'(P_ALLR));
    check("rst_mid_timer", 16'(phase_timer), 16'd0);
    check("rst_mid_pulses", 16'({lamp_err, seq_err, dur_err, fault_sticky}), 16'd0);
    seq_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(L_EWG, 0, 0);
      seq_cnt += int'(seq_err);
    end
    check("post_rst_legal", 16'(seq_cnt), 16'd0);

    // Randomized phase walk against the model
    drv = P_EWG;
    for (int s = 0; s < 350; s++) begin
      if ($urandom_range(0, 7) == 0) begin
        r = 6'($urandom_range(0, 12));
        y = 6'($urandom_range(0, 6));
      end
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        len = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) begin
          v = 6'($urandom);
          step(v, ($urandom_range(0, 7) == 0), 1'b0);
        end
        drv = P_ILL;
        continue;
      end else if (kind == 1) begin
        drv = P_ALLR;
        len = $urandom_range(1, 4);
      end else if (kind == 2) begin
        case ($urandom_range(0, 3))
          0: drv = P_EWG;
          1: drv = P_EWY;
          2: drv = P_SNG;
          default: drv = P_SNY;
        endcase
        len = $urandom_range(1, 8);
      end else begin
        drv = successor(drv);
        len = ((drv == P_EWG || drv == P_SNG) ? int'(r) : int'(y)) + $urandom_range(0, 4) - 2;
        if (len < 1) len = 1;
      end
      for (int i = 0; i < len; i++)
        step(lamps_of(drv), ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
